apb_master_arbiter: RTL and testbench

- Round-robin APB master that shares one APB bus between NREQ internal requesters and the GPIO slave.
- Sequences each transfer through the APB IDLE/SETUP/ACCESS phases and waits for PREADY.
- Returns read data and error status to the granted requester.
- Guards the bus with a wait-state timeout so a hung slave cannot stall the requesters.

---
 rtl/apb_master_arbiter.sv | 173 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one bus among NREQ requesters; IDLE/SETUP/ACCESS sequencing, wait-state timeout.
// All outputs registered; zero-wait transfer completes 3 cycles after the request is sampled in IDLE.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_done,
  output logic [DW-1:0]     req_rdata,
  output logic              req_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AW-1:0]     PADDR,
  output logic [DW-1:0]     PWDATA,
  input  logic [DW-1:0]     PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   elig;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     ptr_next;

  // A requester completing this cycle is still showing its old req_valid; keep it out of arbitration.
  assign elig = req_valid & ~done_q;

  // Scan from the pointer upward with wrap; iterating downward lets the nearest candidate win.
  always_comb begin
    logic [PW:0] pos;
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (PW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (elig[pos[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = pos[PW-1:0];
      end
    end
  end

  assign ptr_next = (owner_q == LAST_REQ) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (grant_vld) begin
          owner_d  = grant_idx;
          pwrite_d = req_write[grant_idx];
          paddr_d  = req_addr[grant_idx*AW +: AW];
          pwdata_d = req_wdata[grant_idx*DW +: DW];
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          done_d[owner_q] = 1'b1;
          rdata_d   = pwrite_q ? '0 : PRDATA;
          err_d     = PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ptr_d     = ptr_next;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d[owner_q] = 1'b1;
          err_d     = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ptr_d     = ptr_next;
          state_d   = S_IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of arbitration and transfer completion.
module tb_apb_master_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_done;
  logic [DW-1:0]     req_rdata;
  logic              req_err;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PSLVERR = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer in flight is an owner plus a count of ACCESS cycles seen.
  logic            m_busy;
  int              m_acc;
  int              m_owner, m_ptr;
  logic            m_w;
  logic [AW-1:0]   m_a;
  logic [DW-1:0]   m_wd;
  logic [NREQ-1:0] m_done;
  logic [DW-1:0]   m_rd;
  logic            m_err;

  task automatic m_reset();
    m_busy = 0; m_acc = 0; m_owner = 0; m_ptr = 0;
    m_w = 0; m_a = '0; m_wd = '0; m_done = '0; m_rd = '0; m_err = 0;
  endtask

  task automatic m_finish(input logic e, input logic [DW-1:0] d);
    m_busy = 0;
    m_done[m_owner] = 1'b1;
    m_err = e;
    m_rd = d;
    m_ptr = (m_owner + 1) % NREQ;
  endtask

  task automatic m_step();
    logic [NREQ-1:0] elig;
    int idx;
    bit found;
    elig = req_valid & ~m_done;
    m_done = '0; m_rd = '0; m_err = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && elig[idx]) begin found = 1; m_owner = idx; end
      end
      if (found) begin
        m_busy = 1; m_acc = 0;
        m_w  = req_write[m_owner];
        m_a  = req_addr[m_owner*AW +: AW];
        m_wd = req_wdata[m_owner*DW +: DW];
      end
    end else if (m_acc == 0) m_acc = 1;
    else if (PREADY) m_finish(PSLVERR, m_w ? '0 : PRDATA);
    else if (m_acc == TO) m_finish(1'b1, '0);
    else m_acc++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge PCLK or negedge PRESETn);
      if (!PRESETn) m_reset();
      else m_step();
    end
  end

  always @(negedge PCLK) begin
    if (cmp_en) begin
      chk("PSEL", PSEL, m_busy);
      chk("PENABLE", PENABLE, m_busy && m_acc >= 1);
      chk("req_done", req_done, m_done);
      if (m_done != 0) begin
        chk("req_rdata", req_rdata, m_rd);
        chk("req_err", req_err, m_err);
      end
      if (m_busy) begin
        chk("PADDR", PADDR, m_a);
        chk("PWRITE", PWRITE, m_w);
        chk("PWDATA", PWDATA, m_wd);
      end
    end
  end

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic new_req(input int i);
    req_write[i] = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW] = AW'($urandom);
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int cnt, gap, last_t, nd;
  int owners[4];
  int rdy_pct;
  int pct_tab[4] = '{100, 60, 25, 0};

  initial begin
    repeat (3) tick();
    chk("rst PSEL", PSEL, 0);
    chk("rst PENABLE", PENABLE, 0);
    chk("rst req_done", req_done, 0);
    chk("rst PADDR", PADDR, 0);
    chk("rst req_err", req_err, 0);
    PRESETn = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Single zero-wait write from requester 0.
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 8'h04; req_wdata[0 +: DW] = 32'hA5A5_0001; PREADY = 1'b1;
    tick();
    chk("wr setup PSEL", PSEL, 1);
    chk("wr setup PENABLE", PENABLE, 0);
    chk("wr PADDR", PADDR, 8'h04);
    tick();
    chk("wr access PENABLE", PENABLE, 1);
    chk("wr PWDATA", PWDATA, 32'hA5A5_0001);
    tick();
    chk("wr done", req_done, 2'b01);
    chk("wr err", req_err, 0);
    chk("wr PSEL low", PSEL, 0);
    req_valid = '0;
    tick();

    // Read from requester 1 with three wait states.
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 8'h08; PREADY = 1'b0;
    PRDATA = 32'h0000_00FF;
    tick();
    for (int a = 1; a <= 4; a++) begin
      tick();
      if (a == 4) PREADY = 1'b1;
      chk("rd PENABLE held", PENABLE, 1);
      chk("rd PADDR held", PADDR, 8'h08);
    end
    tick();
    chk("rd done", req_done, 2'b10);
    chk("rd rdata", req_rdata, 32'h0000_00FF);
    req_valid = '0; PREADY = 1'b0;
    tick();

    // Hung slave: read from requester 0 aborts after TO ACCESS cycles.
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 8'h3C; PRDATA = 32'hDEAD_BEEF;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (PENABLE) cnt++;
      if (req_done != 0) break;
    end
    chk("to access cycles", cnt, TO);
    chk("to done", req_done, 2'b01);
    chk("to err", req_err, 1);
    chk("to rdata", req_rdata, 0);
    chk("to PSEL", PSEL, 0);
    req_valid = '0;
    tick();

    // Slave error on a write from requester 1.
    req_valid = 2'b10; req_write = 2'b10; req_addr[AW +: AW] = 8'h10; PREADY = 1'b1; PSLVERR = 1'b1;
    repeat (3) tick();
    chk("slverr done", req_done, 2'b10);
    chk("slverr err", req_err, 1);
    req_valid = '0; PSLVERR = 1'b0;
    tick();

    // Contention: both held valid; grants must alternate starting at 0.
    req_valid = 2'b11; req_write = 2'b11; nd = 0; last_t = 0;
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      tick();
      if (req_done != 0) begin
        owners[nd] = (req_done == 2'b10) ? 1 : 0;
        if (nd > 0) chk("contention gap", c - last_t, 3);
        last_t = c;
        nd++;
      end
    end
    chk("contention count", nd, 4);
    for (int i = 0; i < 4; i++) chk("contention order", owners[i], i % 2);
    req_valid = '0;
    tick();

    // Asynchronous reset in the middle of ACCESS.
    req_valid = 2'b10; req_write = 2'b00; req_addr[AW +: AW] = 8'h22; PREADY = 1'b0;
    repeat (2) tick();
    chk("rstmid PENABLE before", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rstmid PSEL", PSEL, 0);
    chk("rstmid PENABLE", PENABLE, 0);
    chk("rstmid req_done", req_done, 0);
    tick();
    PRESETn = 1'b1;
    tick();
    chk("rstmid regrant PSEL", PSEL, 1);
    chk("rstmid regrant PADDR", PADDR, 8'h22);
    req_valid = '0;
    repeat (20) tick();

    // Random traffic checked only by the model.
    rdy_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 250 == 0) rdy_pct = pct_tab[$urandom_range(0, 3)];
      for (int i = 0; i < NREQ; i++) begin
        if (req_done[i]) begin
          if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
          else new_req(i);
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < 30) begin req_valid[i] = 1'b1; new_req(i); end
        end else if ($urandom_range(0, 99) < 3) begin
          req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 10) begin
          new_req(i);
        end
      end
      PREADY  = ($urandom_range(0, 99) < rdy_pct);
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 3) == 0);
    end
    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
